serial_mag_comp: RTL and testbench
==================================

Name: serial_mag_comp

Overview:
Sequential wide-operand magnitude comparator built around the existing 4-bit cascadable slice comp_4.
- Latches two WIDTH-bit operands on start.
- Walks them one nibble per cycle, LSB nibble first, feeding the registered previous result into the slice's cascade inputs.
- Reports one-hot GT/EQ/LT with a done pulse.
- Sits upstream of comp_4: it generates the cascade inputs and consumes the cascade outputs, replacing a combinational chain of WIDTH/4 slices.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4; otherwise elaboration error.
- NIBS, WIDTH/4, derived localparam: number of nibble steps.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a comparison; sampled on clk rising edge
- a  input  WIDTH  operand A; sampled only when start is accepted
- b  input  WIDTH  operand B; sampled only when start is accepted
- busy  output  1  high while nibble steps are in progress
- done  output  1  one-cycle pulse: result valid and updated
- a_gt_b  output  1  registered result A>B (unsigned)
- a_eq_b  output  1  registered result A==B
- a_lt_b  output  1  registered result A<B

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0.
  - a_gt_b=0, a_eq_b=0, a_lt_b=0 (the only all-zero result state).
  - Operand registers and nibble counter cleared.
- FSM states:
  - IDLE: start=1 → latch a, b; idx=0; cascade regs gt=0, eq=1, lt=0; go to RUN.
  - RUN: each cycle, present nibble idx of A/B and the cascade regs to comp_4, then load the comp_4 outputs into the cascade regs. If idx==NIBS-1, go to DONE; else idx=idx+1.
  - DONE: done=1 for exactly this cycle. Cascade regs are copied to a_gt_b/a_eq_b/a_lt_b on entry, so the outputs are valid in the same cycle as done. Next state: start=1 → behave as IDLE+start (back-to-back accepted); start=0 → IDLE.
- Timing, with start sampled high at the end of cycle 0:
  - busy=1 in cycles 1..NIBS.
  - done=1 in cycle NIBS+1.
  - Total latency NIBS+1 cycles.
- Results hold their value until the next DONE. They do not change during RUN.
- Result flags are one-hot after the first completed comparison.
- Cascade rule per step, inherited from comp_4:
  - A nibble that differs decides the result.
  - An equal nibble passes the lower result through.
  - With eq=0 and gt=0 propagated, lt=1.
  - The initial cascade (gt=0, eq=1, lt=0) makes all-equal operands yield EQ.
- start while busy=1 is ignored. No queueing; operands are not re-sampled.
- a and b may change freely after acceptance; only the latched copies are used.
- Index counter width: clog2(NIBS), minimum 1. No wrap-around occurs; the counter stops at NIBS-1.
- Reset asserted mid-RUN aborts immediately:
  - No done pulse.
  - Results return to 0.
  - After release, the block stays idle until a new start.
- WIDTH=4 (NIBS=1): a single RUN cycle; done in cycle 2.
- Comparison is unsigned only.

Decomposition:
- Shared package/header:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - NIBBLE_W=4.
  - Reset/initial cascade constants: CASC_INIT_GT=0, CASC_INIT_EQ=1, CASC_INIT_LT=0.
- Sub-module: one instance of comp_4, driven by the muxed nibble pair and the cascade registers.
- All sequencing, latching and output registering stays in serial_mag_comp.

Test Plan:
- WIDTH=16, a=16'h1234, b=16'h1234, start pulse in cycle 0 → busy cycles 1–4; done=1 only in cycle 5; eq=1, gt=0, lt=0.
- a=16'h8000, b=16'h7FFF → gt=1 at done, even though the three lower nibbles compare A<B; a=16'h00FF, b=16'h0100 → lt=1.
- Hold start=1 during RUN with new operands 16'hFFFF/16'h0000 → ignored; the first result is unchanged; a second start asserted in the DONE cycle is accepted, giving the next done 5 cycles later with gt=1.
- Drop rst_n in cycle 2 of a RUN → busy, done and all result flags go to 0 asynchronously; no done pulse afterwards; idle until the next start.
- Directed sweep over 32 random pairs plus a=0/b=0 and a=FFFF/b=FFFF → results match the unsigned reference; flags are one-hot at every done.
- Elaborate WIDTH=4: a=4'h9, b=4'h6 → gt=1 with done in cycle 2; WIDTH=6 → elaboration error.

Source files
------------

// File: rtl/serial_mag_comp_pkg.sv
// Shared constants for the nibble-serial magnitude comparator: FSM encoding,
// slice width and the cascade seed that makes all-equal operands report EQ.
package serial_mag_comp_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic CASC_INIT_GT = 1'b0;
  localparam logic CASC_INIT_EQ = 1'b1;
  localparam logic CASC_INIT_LT = 1'b0;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } casc_t;

  localparam casc_t CASC_INIT = '{gt: CASC_INIT_GT, eq: CASC_INIT_EQ, lt: CASC_INIT_LT};

endpackage

// File: rtl/serial_mag_comp_comp_4.sv
// comp_4: combinational 4-bit cascadable magnitude slice, zero latency, no flow control.
// A differing nibble decides; an equal nibble passes the lower-order cascade through.
module comp_4
  import serial_mag_comp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  casc_t               casc_i,
  output casc_t               casc_o
);

  always_comb begin
    casc_o = '0;
    if (a_i > b_i) begin
      casc_o.gt = 1'b1;
    end else if (a_i < b_i) begin
      casc_o.lt = 1'b1;
    end else begin
      // eq dominates; with neither eq nor gt propagated the slice reports lt
      casc_o.eq = casc_i.eq;
      casc_o.gt = ~casc_i.eq & casc_i.gt;
      casc_o.lt = ~casc_i.eq & (casc_i.lt | ~casc_i.gt);
    end
  end

endmodule

// File: rtl/serial_mag_comp.sv
// Sequential WIDTH-bit unsigned comparator, one nibble per cycle LSB first; done NIBS+1 cycles
// after start. start is ignored while busy; a start in the done cycle is accepted back-to-back.
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int NIBS  = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBS - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("serial_mag_comp: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  casc_t            casc_q, casc_d, res_q, res_d, casc_nxt;
  logic [NIBBLE_W-1:0] a_nib, b_nib;
  logic             accept;

  assign a_nib = NIBBLE_W'(a_q >> (idx_q * NIBBLE_W));
  assign b_nib = NIBBLE_W'(b_q >> (idx_q * NIBBLE_W));

  comp_4 u_comp_4 (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .casc_i (casc_q),
    .casc_o (casc_nxt)
  );

  assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    casc_d  = casc_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        casc_d = casc_nxt;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          res_d   = casc_nxt;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = ST_RUN;
      idx_d   = '0;
      a_d     = a;
      b_d     = b;
      casc_d  = CASC_INIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      casc_q  <= CASC_INIT;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      casc_q  <= casc_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign a_gt_b = res_q.gt;
  assign a_eq_b = res_q.eq;
  assign a_lt_b = res_q.lt;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed bench for serial_mag_comp at WIDTH=16 and WIDTH=4.
module tb_serial_mag_comp;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  exp;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] exp;
  } vec4_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, gt, eq, lt;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4, gt4, eq4, lt4;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_mag_comp #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .a_gt_b(gt), .a_eq_b(eq), .a_lt_b(lt)
  );

  serial_mag_comp #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .a_gt_b(gt4), .a_eq_b(eq4), .a_lt_b(lt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; returns just after the edge following done.
  task automatic do_cmp(input logic [15:0] va, input logic [15:0] vb, input logic [2:0] exp);
    logic [2:0] hold;
    hold  = {gt, eq, lt};
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a     = ~va;
    b     = ~vb;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("busy", {31'd0, busy}, (c <= 4) ? 32'd1 : 32'd0);
      chk("done", {31'd0, done}, (c == 5) ? 32'd1 : 32'd0);
      if (c <= 4) chk("hold_in_run", {29'd0, gt, eq, lt}, {29'd0, hold});
      else        chk("result", {29'd0, gt, eq, lt}, {29'd0, exp});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vec_t  tbl[12];
    vec4_t tbl4[3];
    logic [15:0] ra, rb;
    logic [2:0]  rexp, hold;

    tbl[0]  = '{16'h0000, 16'h0000, EQ};
    tbl[1]  = '{16'hFFFF, 16'hFFFF, EQ};
    tbl[2]  = '{16'h0001, 16'h0000, GT};
    tbl[3]  = '{16'h0000, 16'h0001, LT};
    tbl[4]  = '{16'hF000, 16'h0FFF, GT};
    tbl[5]  = '{16'h1234, 16'h1235, LT};
    tbl[6]  = '{16'hABCD, 16'hABCC, GT};
    tbl[7]  = '{16'h7FFF, 16'h8000, LT};
    tbl[8]  = '{16'h0010, 16'h0001, GT};
    tbl[9]  = '{16'h5A5A, 16'h5A5A, EQ};
    tbl[10] = '{16'h8001, 16'h8010, LT};
    tbl[11] = '{16'hFFFE, 16'hFFFF, LT};
    tbl4[0] = '{4'h9, 4'h6, GT};
    tbl4[1] = '{4'h3, 4'h3, EQ};
    tbl4[2] = '{4'h2, 4'hB, LT};

    #12;
    chk("reset_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_cmp(16'h1234, 16'h1234, EQ);
    do_cmp(16'h8000, 16'h7FFF, GT);
    do_cmp(16'h00FF, 16'h0100, LT);

    // start held through RUN with new operands; the copy taken in DONE is the second job
    hold  = {gt, eq, lt};
    a     = 16'h1111;
    b     = 16'h2222;
    start = 1'b1;
    @(posedge clk); #1;
    a = 16'hFFFF;
    b = 16'h0000;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk("b2b_busy", {31'd0, busy}, ((c >= 1 && c <= 4) || (c >= 6 && c <= 9)) ? 32'd1 : 32'd0);
      chk("b2b_done", {31'd0, done}, (c == 5 || c == 10) ? 32'd1 : 32'd0);
      if (c <= 4)      chk("b2b_hold", {29'd0, gt, eq, lt}, {29'd0, hold});
      else if (c <= 9) chk("b2b_first", {29'd0, gt, eq, lt}, {29'd0, LT});
      else             chk("b2b_second", {29'd0, gt, eq, lt}, {29'd0, GT});
      @(posedge clk); #1;
      if (c == 5) start = 1'b0;
    end

    // reset dropped in cycle 2 of a RUN
    a     = 16'h8000;
    b     = 16'h0001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_reset_idle", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) do_cmp(tbl[i].a, tbl[i].b, tbl[i].exp);

    for (int i = 0; i < 32; i++) begin
      ra = 16'($urandom);
      rb = (i % 8 == 0) ? ra : 16'($urandom);
      rexp = (ra > rb) ? GT : ((ra == rb) ? EQ : LT);
      do_cmp(ra, rb, rexp);
    end

    for (int i = 0; i < 3; i++) begin
      a4     = tbl4[i].a;
      b4     = tbl4[i].b;
      start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(negedge clk);
      chk("w4_busy_c1", {30'd0, busy4, done4}, 32'd2);
      @(negedge clk);
      chk("w4_done_c2", {30'd0, busy4, done4}, 32'd1);
      chk("w4_result", {29'd0, gt4, eq4, lt4}, {29'd0, tbl4[i].exp});
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
